// File: rtl/noc_pkg.sv
// noc_pkg
//   Shared definitions for the NoC router input stage:
//   - flit type codes carried in the two MSBs of every flit
//   - output port encodings used by the routing logic and crossbar
//   - route-compute FSM state encodings
//   - helpers locating the destination coordinate fields in a head flit
package noc_pkg;

  localparam int FLIT_TYPE_W = 2;
  localparam int PORT_W      = 3;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic [PORT_W-1:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  // dest_y sits in the lowest COORD_W bits, dest_x directly above it.
  function automatic int dest_x_lsb(input int coord_w);
    return coord_w;
  endfunction

  function automatic int dest_y_lsb();
    return 0;
  endfunction

  // A flit that opens a packet (carries routing info).
  function automatic logic is_head_type(input flit_type_e t);
    return (t == HEAD) || (t == HEADTAIL);
  endfunction

  // A flit that closes a packet.
  function automatic logic is_last_type(input flit_type_e t);
    return (t == TAIL) || (t == HEADTAIL);
  endfunction

endpackage

// File: rtl/xy_routing.sv
// xy_routing
//   Purely combinational dimension-ordered (X first, then Y) routing.
//   Kept standalone so the lookahead routing stage can reuse it.
// Parameters:
//   COORD_W      width of one mesh coordinate
//   CUR_X/CUR_Y  coordinates of the router doing the routing
// Ports:
//   dest_x, dest_y  destination coordinates (unsigned)
//   port            selected output port (noc_pkg::port_e encoding)
module xy_routing
  import noc_pkg::*;
#(
  parameter int COORD_W = 2,
  parameter int CUR_X   = 0,
  parameter int CUR_Y   = 0
) (
  input  logic [COORD_W-1:0] dest_x,
  input  logic [COORD_W-1:0] dest_y,
  output logic [PORT_W-1:0]  port
);

  localparam logic [COORD_W-1:0] HERE_X = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] HERE_Y = COORD_W'(CUR_Y);

  // X is resolved completely before Y, which keeps XY routing deadlock-free.
  always_comb begin
    port = LOCAL;
    if (dest_x > HERE_X) begin
      port = EAST;
    end else if (dest_x < HERE_X) begin
      port = WEST;
    end else if (dest_y > HERE_Y) begin
      port = NORTH;
    end else if (dest_y < HERE_Y) begin
      port = SOUTH;
    end
  end

endmodule

// File: rtl/route_compute_unit.sv
// route_compute_unit
//   Input-port stage behind the per-port flit buffer. Decodes each head
//   flit, computes its XY output port, requests the switch allocator and,
//   once granted, streams the packet to the crossbar up to its tail.
// Parameters:
//   FLIT_SIZE    flit width; two MSBs hold the flit type
//   COORD_W      width of one mesh coordinate
//   CUR_X/CUR_Y  coordinates of this router
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   data_i, empty_i    buffer head flit and buffer empty flag
//   read_o             pops the buffer head this cycle
//   req_o, out_port_o  switch-allocation request and requested port
//   grant_i            allocator grant (only looked at while requesting)
//   flit_o, flit_valid_o, ready_i  crossbar flit, valid and accept
//   error_o            one-cycle pulse per orphan flit dropped while idle
module route_compute_unit
  import noc_pkg::*;
#(
  parameter int FLIT_SIZE = 32,
  parameter int COORD_W   = 2,
  parameter int CUR_X     = 0,
  parameter int CUR_Y     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 empty_i,
  output logic                 read_o,
  output logic                 req_o,
  output logic [PORT_W-1:0]    out_port_o,
  input  logic                 grant_i,
  output logic [FLIT_SIZE-1:0] flit_o,
  output logic                 flit_valid_o,
  input  logic                 ready_i,
  output logic                 error_o
);

  localparam int DX_LSB = dest_x_lsb(COORD_W);
  localparam int DY_LSB = dest_y_lsb();

  state_e             state;
  flit_type_e         flit_type;
  logic               head_flit;
  logic               last_flit;
  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;
  logic [PORT_W-1:0]  route;

  assign flit_type = flit_type_e'(data_i[FLIT_SIZE-1 -: FLIT_TYPE_W]);
  assign head_flit = is_head_type(flit_type);
  assign last_flit = is_last_type(flit_type);
  assign dest_x    = data_i[DX_LSB +: COORD_W];
  assign dest_y    = data_i[DY_LSB +: COORD_W];

  xy_routing #(
    .COORD_W (COORD_W),
    .CUR_X   (CUR_X),
    .CUR_Y   (CUR_Y)
  ) u_xy_routing (
    .dest_x (dest_x),
    .dest_y (dest_y),
    .port   (route)
  );

  // The crossbar sees the buffer head directly; no extra pipeline stage.
  assign flit_o       = data_i;
  assign req_o        = (state != IDLE);
  assign flit_valid_o = (state == ACTIVE) && !empty_i;

  // Pops happen either to forward a granted packet or to discard an orphan
  // body/tail seen while idle. Gated by rst so no pop is issued while reset
  // is held, even though the idle drop condition may be true then.
  always_comb begin
    read_o = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    read_o = !empty_i && !head_flit;
        ACTIVE:  read_o = !empty_i && ready_i;
        default: read_o = 1'b0;
      endcase
    end
  end

  // The head is left in the buffer while requesting; it is the first flit
  // popped once ACTIVE, so the packet leaves the buffer intact and in order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      out_port_o <= '0;
      error_o    <= 1'b0;
    end else begin
      error_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty_i) begin
            if (head_flit) begin
              out_port_o <= route;
              state      <= REQ;
            end else begin
              error_o <= 1'b1;
            end
          end
        end
        REQ: begin
          if (grant_i) begin
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (read_o && last_flit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_route_compute_unit.sv
// tb_route_compute_unit
//   Self-checking bench for route_compute_unit (CUR_X=1, CUR_Y=1). A queue
//   stands in for the flit buffer; a packet-level reference model predicts
//   every output each cycle. Directed scenarios come first, then randomized
//   packets with random ready, buffer starvation and grant delay.
module tb_route_compute_unit;

  localparam int FW = 32;
  localparam int CW = 2;
  localparam int HX = 1;
  localparam int HY = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] data_i;
  logic          empty_i;
  logic          read_o;
  logic          req_o;
  logic [2:0]    out_port_o;
  logic          grant_i;
  logic [FW-1:0] flit_o;
  logic          flit_valid_o;
  logic          ready_i;
  logic          error_o;

  route_compute_unit #(
    .FLIT_SIZE (FW),
    .COORD_W   (CW),
    .CUR_X     (HX),
    .CUR_Y     (HY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .empty_i      (empty_i),
    .read_o       (read_o),
    .req_o        (req_o),
    .out_port_o   (out_port_o),
    .grant_i      (grant_i),
    .flit_o       (flit_o),
    .flit_valid_o (flit_valid_o),
    .ready_i      (ready_i),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Buffer contents and packet-level model state.
  logic [FW-1:0] buf_q[$];
  bit            have_req;
  bit            granted;
  bit            exp_err;
  int            exp_port;
  int            req_age;
  int            seq = 0;

  // Stimulus knobs.
  bit rand_mode = 0;
  bit ready_k   = 1;
  bit hide_k    = 0;
  bit noise_k   = 0;
  int gdelay    = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // XY rule with plain arithmetic: X first, then Y.
  function automatic int ref_route(input int dx, input int dy);
    if (dx > HX) return 3;
    if (dx < HX) return 4;
    if (dy > HY) return 1;
    if (dy < HY) return 2;
    return 0;
  endfunction

  task automatic push_flit(input logic [1:0] t, input int dx, input int dy);
    logic [FW-1:0] f;
    f        = FW'($urandom);
    f[31:30] = t;
    f[29:16] = 14'(seq);
    f[3:2]   = 2'(dx);
    f[1:0]   = 2'(dy);
    seq++;
    buf_q.push_back(f);
  endtask

  task automatic push_packet(input int len, input int dx, input int dy);
    if (len == 1) begin
      push_flit(2'b11, dx, dy);
    end else begin
      push_flit(2'b00, dx, dy);
      for (int i = 1; i < len - 1; i++) push_flit(2'b01, dx, dy);
      push_flit(2'b10, dx, dy);
    end
  endtask

  function automatic void model_reset();
    have_req = 0;
    granted  = 0;
    exp_err  = 0;
    exp_port = 0;
    req_age  = 0;
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // advance the model at the rising edge. Entered and left 1 time unit
  // after a rising edge.
  task automatic apply_stimulus();
    logic [FW-1:0] head;
    logic [1:0]    t;
    bit emp, hd, last, drop, exp_rd, exp_fv;
    if (rand_mode) begin
      ready_k = ($urandom_range(0, 3) != 0);
      hide_k  = ($urandom_range(0, 5) == 0);
      noise_k = 1'($urandom_range(0, 1));
    end
    emp  = hide_k || (buf_q.size() == 0);
    head = (buf_q.size() == 0) ? '0 : buf_q[0];
    t    = head[31:30];
    hd   = (t == 2'b00) || (t == 2'b11);
    last = (t == 2'b10) || (t == 2'b11);
    data_i  = head;
    empty_i = emp;
    ready_i = ready_k;
    grant_i = have_req ? (req_age >= gdelay) : (rand_mode && noise_k);
    drop   = !have_req && !emp && !hd;
    exp_rd = granted ? (!emp && ready_k) : drop;
    exp_fv = granted && !emp;
    @(negedge clk);
    check_output("req", 32'(req_o), 32'(have_req));
    if (have_req) check_output("out_port", 32'(out_port_o), 32'(exp_port));
    check_output("read", 32'(read_o), 32'(exp_rd));
    check_output("flit_valid", 32'(flit_valid_o), 32'(exp_fv));
    if (exp_fv) check_output("flit", flit_o, head);
    check_output("error", 32'(error_o), 32'(exp_err));
    @(posedge clk);
    exp_err = drop;
    if (!have_req) begin
      if (!emp && hd) begin
        have_req = 1;
        exp_port = ref_route(int'(head[3:2]), int'(head[1:0]));
        req_age  = 0;
      end
    end else begin
      req_age++;
      if (!granted) begin
        if (grant_i) granted = 1;
      end else if (exp_rd && last) begin
        have_req = 0;
        granted  = 0;
      end
    end
    if (exp_rd) void'(buf_q.pop_front());
    #1;
  endtask

  task automatic run_until_idle(input string tag, input int max_cycles);
    bit done;
    done = 0;
    for (int i = 0; i < max_cycles; i++) begin
      if (buf_q.size() == 0 && !have_req) begin
        done = 1;
        break;
      end
      apply_stimulus();
    end
    if (!done) done = (buf_q.size() == 0 && !have_req);
    check_output({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  initial begin
    model_reset();
    rst     = 1'b0;
    grant_i = 1'b0;
    ready_i = 1'b1;
    // An orphan body at the head while reset is held must not be popped.
    data_i  = {2'b01, 30'h0};
    empty_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("rst_req", 32'(req_o), 32'd0);
    check_output("rst_read", 32'(read_o), 32'd0);
    check_output("rst_fvalid", 32'(flit_valid_o), 32'd0);
    check_output("rst_error", 32'(error_o), 32'd0);
    check_output("rst_port", 32'(out_port_o), 32'd0);
    empty_i = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("[TB] three-flit packet to (3,1)");
    gdelay = 1;
    push_packet(3, 3, 1);
    run_until_idle("east", 20);
    apply_stimulus();

    $display("[TB] single-flit packets LOCAL/SOUTH/WEST, back to back");
    gdelay = 0;
    push_packet(1, 1, 1);
    push_packet(1, 1, 0);
    push_packet(1, 0, 3);
    run_until_idle("single", 30);

    $display("[TB] head held while grant withheld");
    gdelay = 5;
    push_packet(2, 1, 2);
    run_until_idle("north_wait", 20);

    $display("[TB] ready toggling and buffer starvation mid-packet");
    gdelay = 0;
    push_packet(5, 2, 3);
    for (int i = 0; i < 10; i++) begin
      ready_k = (i < 3) ? 1'b1 : (i == 3 || i == 4) ? 1'b0 : 1'b1;
      hide_k  = (i == 6 || i == 7);
      apply_stimulus();
    end
    ready_k = 1;
    hide_k  = 0;
    run_until_idle("stall", 20);

    $display("[TB] orphan body then a normal head");
    push_flit(2'b01, 0, 0);
    push_packet(2, 3, 0);
    run_until_idle("orphan", 20);
    apply_stimulus();

    $display("[TB] asynchronous reset mid-packet");
    gdelay = 0;
    push_packet(6, 2, 1);
    for (int i = 0; i < 4; i++) apply_stimulus();
    data_i  = buf_q[0];
    empty_i = 1'b0;
    ready_i = 1'b1;
    grant_i = 1'b1;
    #1;
    check_output("pre_rst_read", 32'(read_o), 32'(granted));
    #1;
    rst = 1'b0;
    #1;
    check_output("arst_req", 32'(req_o), 32'd0);
    check_output("arst_read", 32'(read_o), 32'd0);
    check_output("arst_fvalid", 32'(flit_valid_o), 32'd0);
    check_output("arst_port", 32'(out_port_o), 32'd0);
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    run_until_idle("leftover", 20);
    push_packet(3, 0, 1);
    run_until_idle("fresh", 20);
    apply_stimulus();

    $display("[TB] randomized packets");
    rand_mode = 1;
    for (int p = 0; p < 40; p++) begin
      gdelay = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) push_flit(($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, 0, 0);
      push_packet($urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) push_packet($urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 3));
      run_until_idle("random", 200);
    end
    rand_mode = 0;
    apply_stimulus();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/route_compute_unit.md
Name: route_compute_unit

Overview:
- Input-port stage directly downstream of the per-port flit buffer in the NoC router.
- Pops flits from the buffer and decodes each head flit.
- Computes the XY-routed output port and requests the switch allocator.
- After the grant, streams the packet's flits to the crossbar until the tail, then releases the request.

Parameters:
FLIT_SIZE, 32, flit width in bits; bits [FLIT_SIZE-1:FLIT_SIZE-2] hold the flit type.
COORD_W, 2, width of one mesh coordinate.
CUR_X, 0, X coordinate of this router.
CUR_Y, 0, Y coordinate of this router.

Ports:
clk  input  1  single clock; all state on the rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
data_i  input  FLIT_SIZE  flit at the buffer head; valid whenever empty_i=0
empty_i  input  1  buffer empty flag
read_o  output  1  pops the buffer head this cycle
req_o  output  1  switch-allocation request
out_port_o  output  3  requested output port, valid while req_o=1 or in ACTIVE
grant_i  input  1  allocator grant; sampled only in REQ
flit_o  output  FLIT_SIZE  flit to crossbar; equals data_i
flit_valid_o  output  1  flit_o is valid
ready_i  input  1  crossbar/downstream accepts flit_o this cycle
error_o  output  1  one-cycle pulse: non-head flit dropped in IDLE

Behaviour:
- Flit types: 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL (single-flit packet).
- In head and headtail flits: dest_x = data_i[2*COORD_W-1:COORD_W], dest_y = data_i[COORD_W-1:0]; both unsigned.
- Port encoding: LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4.
- XY routing, evaluated in order:
  - dest_x > CUR_X: EAST.
  - dest_x < CUR_X: WEST.
  - otherwise dest_y > CUR_Y: NORTH.
  - otherwise dest_y < CUR_Y: SOUTH.
  - otherwise LOCAL.
- State machine states: IDLE, REQ, ACTIVE.
- Reset, asynchronous on rst=0:
  - state=IDLE, out_port_o=0.
  - req_o, read_o, flit_valid_o and error_o are all 0 immediately, with no clock edge needed.
- IDLE:
  - empty_i=1: stay in IDLE.
  - empty_i=0 and type is HEAD or HEADTAIL: register the route into out_port_o; next state REQ. The head is not popped.
  - empty_i=0 and type is BODY or TAIL: read_o=1 combinationally in the same cycle (drop the flit); error_o=1 registered in the next cycle for exactly one cycle; stay in IDLE.
- REQ:
  - req_o=1.
  - grant_i=1 at a rising edge: next state ACTIVE.
  - Otherwise stay in REQ; req_o and out_port_o are held stable.
- ACTIVE:
  - req_o stays 1.
  - flit_valid_o = ~empty_i.
  - read_o = flit_valid_o & ready_i. A transfer is a cycle with read_o=1.
  - The first flit transferred is the head.
  - A transfer of a TAIL or HEADTAIL flit means next state IDLE, with req_o=0 from that next cycle.
- Latency: a head reaching the buffer output at edge n gives req_o=1 after edge n+1. If grant_i=1 in that cycle, the head can be forwarded in the cycle after edge n+2.
- grant_i is ignored outside REQ. The allocator holds the grant until req_o falls.
- Back-to-back packets: after the tail transfer, a new head in IDLE is routed in the next cycle (one bubble cycle minimum between packets).
- Buffer empty mid-packet in ACTIVE: flit_valid_o=0; wait with no state change.
- ready_i=0: no pop; flit_o stays equal to the unchanged buffer head.
- read_o is never asserted while empty_i=1.
- Reset mid-packet: all state is discarded. Remaining body flits are later dropped in IDLE with error_o pulses; that is the required behaviour.

Decomposition:
- Shared package noc_pkg:
  - flit type constants HEAD, BODY, TAIL, HEADTAIL.
  - port encodings LOCAL, NORTH, SOUTH, EAST, WEST.
  - FSM state encodings.
  - destination field offset helpers.
- Sub-module xy_routing: purely combinational (dest_x, dest_y, CUR_X, CUR_Y → 3-bit port). It is reusable by the lookahead routing stage.

Test Plan:
- CUR_X=1, CUR_Y=1; HEAD dest (3,1), then BODY, then TAIL; grant_i=1 one cycle after req_o rises; ready_i=1 → out_port_o=3 (EAST); three transfers in consecutive cycles; req_o=0 the cycle after the TAIL pop.
- HEADTAIL dest (1,1) → out_port_o=0 (LOCAL); one transfer; back in IDLE. Repeat with dest (1,0) → out_port_o=2 (SOUTH), and dest (0,3) → out_port_o=4 (WEST).
- HEAD dest (1,2) with grant_i held 0 for 5 cycles → req_o=1 and out_port_o=1 stable; read_o=0 throughout; the head is popped only after the grant.
- ACTIVE with ready_i toggling 1,0,0,1 and empty_i=1 for 2 cycles mid-packet → read_o only when ready_i=1 and empty_i=0; flit order preserved; no flit dropped or duplicated.
- BODY flit at buffer head in IDLE → read_o=1 that cycle; error_o=1 for exactly one cycle; the next HEAD is routed normally.
- rst=0 asserted asynchronously mid-packet during ACTIVE → req_o, read_o and flit_valid_o fall to 0 before the next edge. After release, leftover BODY/TAIL flits produce error_o pulses and a fresh HEAD is serviced.
